// File: rtl/csa_seq_accum_pkg.sv
// Shared types and width helpers for the sequential carry-save accumulator.
package csa_seq_accum_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int NUM_OPS_DEFAULT = 10;

    function automatic int cnt_width(input int num_ops);
        return $clog2(num_ops + 1);
    endfunction

    localparam int CNT_W = cnt_width(NUM_OPS_DEFAULT);

endpackage

// File: rtl/csa_seq_accum_csa_3to2.sv
// One width-W carry-save (3:2) stage: per-bit full adder without carry propagation.
module csa_3to2 #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] s,
    output logic [W-1:0] co
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            assign s[gi]  = a[gi] ^ b[gi] ^ c[gi];
            assign co[gi] = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
        end
    endgenerate

endmodule

// File: rtl/csa_seq_accum.sv
// Streaming multi-operand adder: folds NUM_OPS operands into redundant sum/carry
// registers through one reused 3:2 stage, then resolves with a single add.
module csa_seq_accum
    import csa_seq_accum_pkg::*;
#(
    parameter int N       = 8,
    parameter int NUM_OPS = 10,
    parameter int SW      = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             abort,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [N-1:0]                     in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [SW-1:0]                    out_data,
    output logic                             busy,
    output logic [cnt_width(NUM_OPS)-1:0]    op_count
);

    localparam int OP_CNT_W = cnt_width(NUM_OPS);
    localparam logic [OP_CNT_W-1:0] LAST_CNT = OP_CNT_W'(NUM_OPS - 1);

    state_t              state_reg;
    logic [SW-1:0]       sum_reg;
    logic [SW-1:0]       carry_reg;
    logic [OP_CNT_W-1:0] op_count_reg;
    logic [SW-1:0]       out_data_reg;
    logic                out_valid_reg;
    logic                in_ready_reg;
    logic                busy_reg;

    logic [SW-1:0] opx;
    logic [SW-1:0] csa_s;
    logic [SW-1:0] csa_co;
    logic [SW-1:0] carry_next;
    logic          accept;

    assign opx        = SW'(in_data);
    assign accept     = in_valid & in_ready_reg;
    // Carry weight doubles; the bit shifted out of the MSB is dropped (mod 2^SW).
    assign carry_next = {csa_co[SW-2:0], 1'b0};

    csa_3to2 #(
        .W (SW)
    ) u_csa (
        .a  (sum_reg),
        .b  (carry_reg),
        .c  (opx),
        .s  (csa_s),
        .co (csa_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            state_reg     <= IDLE;
            sum_reg       <= '0;
            carry_reg     <= '0;
            op_count_reg  <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, ACCUM: begin
                    if (accept) begin
                        sum_reg   <= csa_s;
                        carry_reg <= carry_next;
                        busy_reg  <= 1'b1;
                        if (state_reg == IDLE) begin
                            op_count_reg <= OP_CNT_W'(1);
                        end else begin
                            op_count_reg <= op_count_reg + OP_CNT_W'(1);
                        end
                        // IDLE always has a count of 0, so NUM_OPS==1 lands here too.
                        if ((state_reg == IDLE && NUM_OPS == 1) ||
                            (state_reg == ACCUM && op_count_reg == LAST_CNT)) begin
                            state_reg    <= RESOLVE;
                            in_ready_reg <= 1'b0;
                        end else begin
                            state_reg    <= ACCUM;
                        end
                    end
                end
                RESOLVE: begin
                    out_data_reg  <= sum_reg + carry_reg;
                    out_valid_reg <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        sum_reg       <= '0;
                        carry_reg     <= '0;
                        op_count_reg  <= '0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    in_ready_reg <= 1'b1;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign busy      = busy_reg;
    assign op_count  = op_count_reg;

endmodule

// File: tb/tb_csa_seq_accum.sv
// Self-checking bench for csa_seq_accum: table vectors, corner-case sequences and
// randomized runs checked against a plain-arithmetic sum model.
module tb_csa_seq_accum;

    localparam int N       = 8;
    localparam int NUM_OPS = 10;
    localparam int SW      = 16;
    localparam int CW      = $clog2(NUM_OPS + 1);

    logic          clk;
    logic          rst_n;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_data;
    logic          busy;
    logic [CW-1:0] op_count;

    int errors = 0;
    int checks = 0;

    csa_seq_accum #(
        .N       (N),
        .NUM_OPS (NUM_OPS),
        .SW      (SW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0][7:0] ops;
        logic [9:0][3:0] gaps;
        logic [15:0]     exp;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present one operand and return at the negedge after it was accepted.
    task automatic send(input logic [7:0] d);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("send_ready_timeout", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_acc(input string name, input logic [9:0][7:0] ops,
                           input logic [9:0][3:0] gaps, input int hold,
                           input logic [15:0] exp);
        out_ready = (hold == 0);
        for (int i = 0; i < NUM_OPS; i++) begin
            send(ops[i]);
            check({name, "_count"}, 32'(op_count), i + 1);
            check({name, "_busy"}, 32'(busy), 1);
            if (i < NUM_OPS - 1) begin
                for (int g = 0; g < int'(gaps[i]); g++) begin
                    @(negedge clk);
                    check({name, "_bubble_count"}, 32'(op_count), i + 1);
                end
            end
        end
        check({name, "_resolve_valid"}, 32'(out_valid), 0);
        check({name, "_resolve_ready"}, 32'(in_ready), 0);
        @(negedge clk);
        check({name, "_valid"}, 32'(out_valid), 1);
        check({name, "_data"}, 32'(out_data), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            @(negedge clk);
            check({name, "_hold_valid"}, 32'(out_valid), 1);
            check({name, "_hold_data"}, 32'(out_data), 32'(exp));
            check({name, "_hold_ready"}, 32'(in_ready), 0);
            check({name, "_hold_count"}, 32'(op_count), NUM_OPS);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({name, "_post_valid"}, 32'(out_valid), 0);
        check({name, "_post_busy"}, 32'(busy), 0);
        check({name, "_post_count"}, 32'(op_count), 0);
        check({name, "_post_ready"}, 32'(in_ready), 1);
        check({name, "_post_data"}, 32'(out_data), 32'(exp));
        $display("run %s: result %0d (expected %0d)", name, out_data, exp);
    endtask

    initial begin
        int a1[10];
        int a2[10];
        logic [9:0][7:0] ops;
        logic [9:0][3:0] gaps;
        int model;

        a1 = '{11, 2, 13, 4, 5, 6, 7, 8, 9, 10};
        a2 = '{3, 14, 5, 6, 7, 8, 19, 10, 0, 0};
        for (int i = 0; i < 4; i++) begin
            tbl[i] = '0;
        end
        for (int i = 0; i < 10; i++) begin
            tbl[0].ops[i] = 8'(a1[i]);
            tbl[1].ops[i] = 8'(a2[i]);
            tbl[2].ops[i] = 8'd255;
            tbl[3].ops[i] = 8'd0;
        end
        tbl[0].exp = 16'd75;
        tbl[1].gaps[3] = 4'd3;
        tbl[1].gaps[6] = 4'd3;
        tbl[1].exp = 16'd72;
        tbl[2].exp = 16'd2550;
        tbl[3].exp = 16'd0;

        rst_n     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_op_count", 32'(op_count), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        for (int v = 0; v < 4; v++) begin
            run_acc($sformatf("vec%0d", v), tbl[v].ops, tbl[v].gaps, 0, tbl[v].exp);
        end

        // Result held in DONE while consumer stalls; stray in_valid pulses ignored.
        run_acc("done_hold", tbl[0].ops, '0, 5, 16'd75);

        // Abort after four operands discards the partial sum.
        for (int i = 0; i < 4; i++) begin
            send(tbl[0].ops[i]);
        end
        check("abort_pre_count", 32'(op_count), 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_count", 32'(op_count), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_data", 32'(out_data), 0);
        check("abort_ready", 32'(in_ready), 1);
        for (int i = 0; i < 10; i++) begin
            ops[i] = 8'd1;
        end
        run_acc("after_abort", ops, '0, 0, 16'd10);

        // Reset mid-accumulation.
        for (int i = 0; i < 6; i++) begin
            send(tbl[0].ops[i]);
        end
        check("rst_mid_pre_count", 32'(op_count), 6);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_count", 32'(op_count), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_valid", 32'(out_valid), 0);
        check("rst_mid_data", 32'(out_data), 0);
        check("rst_mid_ready", 32'(in_ready), 1);
        run_acc("after_rst", tbl[0].ops, '0, 0, 16'd75);

        // Randomized runs against a plain sum model.
        for (int r = 0; r < 20; r++) begin
            model = 0;
            for (int i = 0; i < 10; i++) begin
                ops[i]  = 8'($urandom);
                gaps[i] = 4'($urandom_range(0, 2));
                model   = model + int'(ops[i]);
            end
            run_acc($sformatf("rand%0d", r), ops, gaps, int'($urandom_range(0, 3)),
                    16'(model % 65536));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/csa_seq_accum.md
Name: csa_seq_accum

Overview:
- Sequential multi-operand adder that reuses one carry-save (3:2) stage over many cycles instead of an unrolled CSA tree.
- Accepts NUM_OPS operands, one per handshake, into redundant sum/carry registers, then resolves them with a single carry-propagate add.
- Serves as the area-reduced, streaming counterpart to the team's combinational ten-operand CSA adder; sits between an operand producer and a result consumer, both using valid/ready.

Parameters:
- N, 8, operand width in bits
- NUM_OPS, 10, operands per accumulation (must be >= 1)
- SW, 16, sum/carry/result width; must be >= N + clog2(NUM_OPS) for an exact result

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  reset; one clock; reset is synchronous and active-low
- abort  input  1  synchronous clear of the current accumulation
- in_valid  input  1  operand present
- in_ready  output  1  block will accept operand this cycle
- in_data  input  N  unsigned operand
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result this cycle
- out_data  output  SW  final sum
- busy  output  1  high in any state other than IDLE
- op_count  output  clog2(NUM_OPS+1)  operands accepted in current accumulation

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; sum_reg, carry_reg, op_count, out_data all 0; out_valid=0; busy=0. Reset wins over everything; reset mid-accumulation discards partial state.
- Priority at each edge: rst_n, then abort, then normal operation. abort=1 produces the same register values as reset except that it is not a reset. abort in DONE drops the unconsumed result.
- States: IDLE, ACCUM, RESOLVE, DONE.
- in_ready = 1 in IDLE and ACCUM, 0 in RESOLVE and DONE. Accept = in_valid & in_ready.
- CSA update on accept: opx = zero-extend in_data to SW. sum_reg <= sum_reg ^ carry_reg ^ opx. carry_reg <= {maj(sum_reg, carry_reg, opx)[SW-2:0], 1'b0}, where maj is the bitwise majority. The carry MSB is dropped, so arithmetic is modulo 2^SW. op_count increments by 1.
- IDLE: sum_reg and carry_reg are 0. An accept applies the CSA update and sets op_count=1. Next state is ACCUM, or RESOLVE if NUM_OPS==1.
- ACCUM: an accept applies the CSA update. The accept that makes op_count reach NUM_OPS moves to RESOLVE. in_valid=0 bubbles hold all state, with no timeout.
- RESOLVE: exactly one cycle. out_data <= sum_reg + carry_reg (SW bits, mod 2^SW). Next state is DONE with out_valid=1.
- Latency: last operand accepted at edge k gives out_valid=1 after edge k+1.
- DONE: out_valid=1; out_data stable while out_ready=0. When out_ready=1 at an edge, out_valid goes 0, sum_reg, carry_reg and op_count clear, and state goes to IDLE. No operand is accepted in the same cycle as the result transfer; the earliest next accept is the cycle after.
- out_data keeps its last value after transfer, until the next RESOLVE, reset or abort.
- Back-to-back throughput: NUM_OPS + 2 cycles per result, with no bubbles and out_ready held at 1.

Decomposition:
- Shared package holds the state enum (IDLE/ACCUM/RESOLVE/DONE) and the width helper constant CNT_W = clog2(NUM_OPS+1).
- Natural sub-module: csa_3to2, a parameterized width-W combinational stage with outputs s = a^b^c and co = maj(a,b,c). csa_seq_accum instantiates it at W=SW and applies the shift-left of co itself.
- Remaining FSM, counter and final adder stay in csa_seq_accum.

Test Plan:
- Operands 11,2,13,4,5,6,7,8,9,10, in_valid held 1, out_ready=1 -> out_data=75, out_valid 1 for one cycle, 2 cycles after last accept; busy low afterwards.
- Operands 3,14,5,6,7,8,19,10,0,0 with in_valid dropped for 3 cycles after the 4th and 7th operands -> op_count holds during bubbles; out_data=72.
- Ten operands of 255 -> out_data=2550 (max value; exercises carry chain, no overflow at SW=16).
- out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_data stable at 75, in_ready=0, in_valid pulses ignored; on out_ready=1, return to IDLE with op_count=0.
- abort asserted after 4 operands (11,2,13,4), then 10 operands of 1 -> first run discarded; out_data=10.
- rst_n=0 for one edge mid-ACCUM (op_count=6) -> all outputs 0 and state IDLE next cycle; a following full run of 11..10 gives 75.
